// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: three requester ports plus the single-port RAM command/response.
interface fb_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req0, req1, req2;
   logic              we0, we1, we2;
   logic [ADDR_W-1:0] addr0, addr1, addr2;
   logic [DATA_W-1:0] wdata0, wdata1, wdata2;
   logic              ack0, ack1, ack2;
   logic              rvalid0, rvalid1, rvalid2;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
             wdata0, wdata1, wdata2, mem_rdata,
      input  ack0, ack1, ack2, rvalid0, rvalid1, rvalid2, rdata,
             mem_addr, mem_we, mem_wdata
   );

   modport slave (
      input  req0, req1, req2, we0, we1, we2, addr0, addr1, addr2,
             wdata0, wdata1, wdata2, mem_rdata,
      output ack0, ack1, ack2, rvalid0, rvalid1, rvalid2, rdata,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/fb_arbiter.sv
// Three-way framebuffer RAM arbiter: VGA priority, round-robin sprite/NIOS, anti-starvation override.
module fb_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 8
) (
   input logic         Clk,
   input logic         Reset,
   fb_arbiter_if.slave bus
);
   typedef enum logic {NORMAL, OVERRIDE} state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   state_t            state_q, state_d;
   logic              rr2_q, rr2_d;   // 1: requester 2 preferred, 0: requester 1 preferred
   logic [7:0]        starve_q, starve_d;
   logic [2:0]        req, gnt, lo_pick;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [2:0]        rd1_q, rd2_q;
   logic [DATA_W-1:0] rdata_q;

   assign req = {bus.req2, bus.req1, bus.req0};

   always_comb begin
      gnt      = '0;
      lo_pick  = '0;
      state_d  = NORMAL;
      rr2_d    = rr2_q;
      starve_d = starve_q;

      if (req[1] && req[2]) lo_pick = rr2_q ? 3'b100 : 3'b010;
      else if (req[1])      lo_pick = 3'b010;
      else if (req[2])      lo_pick = 3'b100;

      if (state_q == OVERRIDE && lo_pick != 3'b000) gnt = lo_pick;
      else if (req[0])                              gnt = 3'b001;
      else                                          gnt = lo_pick;
      if (Reset) gnt = '0;

      if (gnt[1])      rr2_d = 1'b1;
      else if (gnt[2]) rr2_d = 1'b0;

      if (gnt[1] || gnt[2] || !(req[1] || req[2])) starve_d = '0;
      else if (starve_q != 8'hFF)                  starve_d = starve_q + 8'd1;

      // Entering OVERRIDE on the edge where the count reaches the limit gives exactly STARVE_MAX lost cycles
      if (state_q == NORMAL && starve_d == STARVE_LIM) state_d = OVERRIDE;
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt[0]) begin
         sel_we = bus.we0; sel_addr = bus.addr0; sel_wdata = bus.wdata0;
      end else if (gnt[1]) begin
         sel_we = bus.we1; sel_addr = bus.addr1; sel_wdata = bus.wdata1;
      end else if (gnt[2]) begin
         sel_we = bus.we2; sel_addr = bus.addr2; sel_wdata = bus.wdata2;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= NORMAL;
         rr2_q       <= 1'b0;
         starve_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         rdata_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr2_q    <= rr2_d;
         starve_q <= starve_d;
         mem_we_q <= (|gnt) & sel_we;
         if (|gnt) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
         end
         rd1_q <= gnt & {3{~sel_we}};
         rd2_q <= rd1_q;
         if (|rd2_q) rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.ack0      = gnt[0];
   assign bus.ack1      = gnt[1];
   assign bus.ack2      = gnt[2];
   assign bus.rvalid0   = rd2_q[0];
   assign bus.rvalid1   = rd2_q[1];
   assign bus.rvalid2   = rd2_q[2];
   // RAM data arrives in the rvalid cycle itself; the register only holds it afterwards
   assign bus.rdata     = (|rd2_q) ? bus.mem_rdata : rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_fb_arbiter;
   localparam int N = 400;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] ram     [0:65535];
   logic [15:0] ref_ram [0:65535];

   fb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
   fb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

   fb_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(8)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
   fb_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (bus0.mem_we) ram[bus0.mem_addr] <= bus0.mem_wdata;
      bus0.mem_rdata <= ram[bus0.mem_addr];
   end
   assign bus1.mem_rdata = '0;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_inputs();
      bus0.req0 = 0; bus0.req1 = 0; bus0.req2 = 0;
      bus0.we0 = 0; bus0.we1 = 0; bus0.we2 = 0;
      bus0.addr0 = 0; bus0.addr1 = 0; bus0.addr2 = 0;
      bus0.wdata0 = 0; bus0.wdata1 = 0; bus0.wdata2 = 0;
      bus1.req0 = 0; bus1.req1 = 0; bus1.req2 = 0;
      bus1.we0 = 0; bus1.we1 = 0; bus1.we2 = 0;
      bus1.addr0 = 0; bus1.addr1 = 0; bus1.addr2 = 0;
      bus1.wdata0 = 0; bus1.wdata1 = 0; bus1.wdata2 = 0;
   endtask

   task automatic apply_reset();
      clr_inputs();
      Reset = 1;
      tick();
      @(negedge Clk);
      Reset = 0;
   endtask

   task automatic test_reset();
      logic [2:0] a, v;
      clr_inputs();
      bus0.req0 = 1; bus0.req1 = 1; bus0.req2 = 1;
      Reset = 1;
      tick(); tick();
      @(negedge Clk);
      a = {bus0.ack2, bus0.ack1, bus0.ack0};
      v = {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0};
      total++; if (a !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", a); end
      total++; if (v !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", v); end
      total++; if (bus0.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus0.mem_we); end
      total++; if (bus0.mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0000", bus0.mem_addr); end
      total++; if (bus0.mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0000", bus0.mem_wdata); end
      total++; if (bus0.rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", bus0.rdata); end
      clr_inputs();
      Reset = 0;
   endtask

   task automatic test_single_read();
      apply_reset();
      tick();
      bus0.req2 = 1; bus0.we2 = 0; bus0.addr2 = 16'h0040;
      @(negedge Clk);
      total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== 3'b100) begin bad++; $display("FAIL single_ack got=%b exp=100", {bus0.ack2, bus0.ack1, bus0.ack0}); end
      tick();
      bus0.req2 = 0;
      @(negedge Clk);
      total++; if (bus0.mem_addr !== 16'h0040 || bus0.mem_we !== 1'b0) begin bad++; $display("FAIL single_cmd got addr=%h we=%b exp addr=0040 we=0", bus0.mem_addr, bus0.mem_we); end
      total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== 3'b000) begin bad++; $display("FAIL single_early_rvalid got=%b exp=000", {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}); end
      tick();
      @(negedge Clk);
      total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== 3'b100) begin bad++; $display("FAIL single_rvalid got=%b exp=100", {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}); end
      total++; if (bus0.rdata !== 16'hBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=beef", bus0.rdata); end
      tick();
      @(negedge Clk);
      total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== 3'b000) begin bad++; $display("FAIL single_rvalid_once got=%b exp=000", {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}); end
      total++; if (bus0.rdata !== 16'hBEEF) begin bad++; $display("FAIL single_rdata_hold got=%h exp=beef", bus0.rdata); end
   endtask

   task automatic test_rr_writes();
      logic [2:0] e;
      apply_reset();
      tick();
      bus0.req1 = 1; bus0.we1 = 1; bus0.addr1 = 16'h0101; bus0.wdata1 = 16'h1111;
      bus0.req2 = 1; bus0.we2 = 1; bus0.addr2 = 16'h0202; bus0.wdata2 = 16'h2222;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         e = (i % 2 == 0) ? 3'b010 : 3'b100;
         total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== e) begin bad++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", i, {bus0.ack2, bus0.ack1, bus0.ack0}, e); end
         if (i > 0) begin
            total++;
            if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== ((i % 2 == 1) ? 16'h0101 : 16'h0202)) begin
               bad++; $display("FAIL rr_cmd cyc=%0d got we=%b addr=%h", i, bus0.mem_we, bus0.mem_addr);
            end
         end
         total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== 3'b000) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=000", i, {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}); end
         tick();
      end
      clr_inputs();
   endtask

   task automatic test_starve();
      logic [2:0] e;
      apply_reset();
      tick();
      bus0.req0 = 1; bus0.addr0 = 16'h0010;
      bus0.req1 = 1; bus0.addr1 = 16'h0011;
      for (int i = 0; i < 27; i++) begin
         @(negedge Clk);
         e = (i % 9 == 8) ? 3'b010 : 3'b001;
         total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== e) begin bad++; $display("FAIL starve_ack cyc=%0d got=%b exp=%b", i, {bus0.ack2, bus0.ack1, bus0.ack0}, e); end
         tick();
      end
      clr_inputs();
   endtask

   task automatic test_back_to_back();
      logic [2:0] e;
      apply_reset();
      tick();
      bus0.req0 = 1; bus0.addr0 = 16'h0020;
      @(negedge Clk);
      total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== 3'b001) begin bad++; $display("FAIL b2b_ack0 got=%b exp=001", {bus0.ack2, bus0.ack1, bus0.ack0}); end
      tick();
      bus0.req0 = 0; bus0.req1 = 1; bus0.addr1 = 16'h0021;
      @(negedge Clk);
      total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== 3'b010) begin bad++; $display("FAIL b2b_ack1 got=%b exp=010", {bus0.ack2, bus0.ack1, bus0.ack0}); end
      tick();
      bus0.req1 = 0; bus0.req2 = 1; bus0.addr2 = 16'h0022;
      @(negedge Clk);
      total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== 3'b100) begin bad++; $display("FAIL b2b_ack2 got=%b exp=100", {bus0.ack2, bus0.ack1, bus0.ack0}); end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            tick();
            bus0.req2 = 0;
            @(negedge Clk);
         end
         e = (k == 3) ? 3'b000 : 3'(1 << k);
         total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== e) begin bad++; $display("FAIL b2b_rvalid k=%0d got=%b exp=%b", k, {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}, e); end
         if (k < 3) begin
            total++;
            if (bus0.rdata !== (16'(16'h0020 + k) ^ 16'h5A5A)) begin
               bad++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, bus0.rdata, 16'(16'h0020 + k) ^ 16'h5A5A);
            end
         end
      end
   endtask

   task automatic test_reset_inflight();
      apply_reset();
      tick();
      bus0.req1 = 1; bus0.addr1 = 16'h0030;
      @(negedge Clk);
      total++; if (bus0.ack1 !== 1'b1) begin bad++; $display("FAIL inflight_ack got=%b exp=1", bus0.ack1); end
      tick();
      bus0.req1 = 0; bus0.req0 = 1; Reset = 1;
      @(negedge Clk);
      total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== 3'b000) begin bad++; $display("FAIL inflight_ack_forced got=%b exp=000", {bus0.ack2, bus0.ack1, bus0.ack0}); end
      tick();
      Reset = 0; bus0.req0 = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         total++;
         if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== 3'b000 || bus0.mem_we !== 1'b0 ||
             bus0.mem_addr !== 16'h0 || bus0.mem_wdata !== 16'h0 || bus0.rdata !== 16'h0) begin
            bad++; $display("FAIL inflight_outputs k=%0d got rv=%b we=%b addr=%h wd=%h rd=%h exp all 0", k,
                            {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.rdata);
         end
         tick();
      end
   endtask

   task automatic test_starve1();
      logic [2:0] e;
      apply_reset();
      tick();
      bus1.req0 = 1;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) bus1.req1 = 1; else bus1.req2 = 1;
         @(negedge Clk);
         total++; if ({bus1.ack2, bus1.ack1, bus1.ack0} !== 3'b001) begin bad++; $display("FAIL s1_lose k=%0d got=%b exp=001", k, {bus1.ack2, bus1.ack1, bus1.ack0}); end
         tick();
         @(negedge Clk);
         e = (k % 2 == 0) ? 3'b010 : 3'b100;
         total++; if ({bus1.ack2, bus1.ack1, bus1.ack0} !== e) begin bad++; $display("FAIL s1_win k=%0d got=%b exp=%b", k, {bus1.ack2, bus1.ack1, bus1.ack0}, e); end
         tick();
         bus1.req1 = 0; bus1.req2 = 0;
      end
      clr_inputs();
   endtask

   task automatic test_random();
      bit          pend [3];
      bit          pwe  [3];
      logic [15:0] pad  [3];
      logic [15:0] pwd  [3];
      int          rv_who [0:N+3];
      logic [15:0] rv_dat [0:N+3];
      logic        c_we   [0:N+3];
      logic [15:0] c_addr [0:N+3];
      logic [15:0] c_wd   [0:N+3];
      int          m_rr, m_starve, g, lo;
      bit          m_ovr;
      logic [15:0] last_rd;
      logic [2:0]  eack, erv;
      for (int i = 0; i < N + 4; i++) begin
         rv_who[i] = -1; rv_dat[i] = 0; c_we[i] = 0; c_addr[i] = 0; c_wd[i] = 0;
      end
      for (int i = 0; i < 3; i++) pend[i] = 0;
      m_rr = 1; m_starve = 0; m_ovr = 0; last_rd = 0;
      apply_reset();
      for (int c = 0; c < N; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && c < N - 12 && $urandom_range(0, 99) < ((i == 0) ? 45 : 35)) begin
               pend[i] = 1;
               pwe[i]  = 1'($urandom_range(0, 1));
               pad[i]  = 16'h0300 + 16'($urandom_range(0, 63));
               pwd[i]  = 16'($urandom);
            end
         end
         bus0.req0 = pend[0]; bus0.we0 = pwe[0]; bus0.addr0 = pad[0]; bus0.wdata0 = pwd[0];
         bus0.req1 = pend[1]; bus0.we1 = pwe[1]; bus0.addr1 = pad[1]; bus0.wdata1 = pwd[1];
         bus0.req2 = pend[2]; bus0.we2 = pwe[2]; bus0.addr2 = pad[2]; bus0.wdata2 = pwd[2];
         @(negedge Clk);

         lo = (pend[1] && pend[2]) ? m_rr : pend[1] ? 1 : pend[2] ? 2 : -1;
         if (m_ovr && lo > 0) g = lo;
         else if (pend[0])    g = 0;
         else                 g = lo;
         if (g == 1) m_rr = 2; else if (g == 2) m_rr = 1;
         if (g == 1 || g == 2 || (!pend[1] && !pend[2])) m_starve = 0;
         else if (m_starve < 255) m_starve++;
         m_ovr = !m_ovr && (m_starve == 8);

         eack = (g >= 0) ? 3'(1 << g) : 3'b000;
         erv  = (rv_who[c] >= 0) ? 3'(1 << rv_who[c]) : 3'b000;
         total++; if ({bus0.ack2, bus0.ack1, bus0.ack0} !== eack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, {bus0.ack2, bus0.ack1, bus0.ack0}, eack); end
         total++;
         if (bus0.mem_we !== c_we[c] || bus0.mem_addr !== c_addr[c] || bus0.mem_wdata !== c_wd[c]) begin
            bad++; $display("FAIL rnd_cmd cyc=%0d got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h", c,
                            bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, c_we[c], c_addr[c], c_wd[c]);
         end
         total++; if ({bus0.rvalid2, bus0.rvalid1, bus0.rvalid0} !== erv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, {bus0.rvalid2, bus0.rvalid1, bus0.rvalid0}, erv); end
         if (rv_who[c] >= 0) last_rd = rv_dat[c];
         total++; if (bus0.rdata !== last_rd) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, bus0.rdata, last_rd); end

         if (g >= 0) begin
            c_we[c+1] = pwe[g]; c_addr[c+1] = pad[g]; c_wd[c+1] = pwd[g];
            if (pwe[g]) ref_ram[pad[g]] = pwd[g];
            else begin rv_who[c+2] = g; rv_dat[c+2] = ref_ram[pad[g]]; end
            pend[g] = 0;
         end else begin
            c_we[c+1] = 0; c_addr[c+1] = c_addr[c]; c_wd[c+1] = c_wd[c];
         end
      end
      clr_inputs();
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         ram[a]     = 16'(a) ^ 16'h5A5A;
         ref_ram[a] = 16'(a) ^ 16'h5A5A;
      end
      ram[16'h0040]     = 16'hBEEF;
      ref_ram[16'h0040] = 16'hBEEF;
      Reset = 1;
      clr_inputs();
      test_reset();
      test_single_read();
      test_rr_writes();
      test_starve();
      test_back_to_back();
      test_reset_inflight();
      test_starve1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: framebuffer word-address width.
REQ-002 Parameter DATA_W, default 16: framebuffer data width.
REQ-003 Parameter STARVE_MAX, default 8: consecutive lost cycles before a low-priority requester overrides VGA; range 1..255.
REQ-004 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 req0/req1/req2  in  1 each  request; 0 = VGA line fetch, 1 = sprite engine, 2 = NIOS bridge.
REQ-007 we0/we1/we2  in  1 each  1 = write, 0 = read.
REQ-008 addr0/addr1/addr2  in  ADDR_W each  word address.
REQ-009 wdata0/wdata1/wdata2  in  DATA_W each  write data.
REQ-010 ack0/ack1/ack2  out  1 each  combinational grant; high in the cycle the request is accepted.
REQ-011 rvalid0/rvalid1/rvalid2  out  1 each  read data valid for that requester.
REQ-012 rdata  out  DATA_W  read data shared by all requesters, qualified by rvalidN.
REQ-013 mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  DATA_W: registered single-port RAM command.
REQ-014 mem_rdata  in  DATA_W: RAM read data, valid exactly one cycle after the command.

Function
REQ-015 At most one ackN shall be high in any cycle; ackN shall be high only when reqN is high.
REQ-016 A requester holds reqN, weN, addrN and wdataN stable until the cycle its ackN is high; the arbiter shall sample them in that cycle.
REQ-017 A grant in cycle t shall drive mem_addr/mem_we/mem_wdata in cycle t+1; with no grant in t, mem_we shall be 0 in t+1 and mem_addr/mem_wdata shall hold.
REQ-018 A granted read in cycle t shall raise rvalidN for exactly one cycle, t+2, with rdata = mem_rdata; a granted write shall never raise rvalidN.
REQ-019 Normal mode: req0 wins whenever high; otherwise round-robin between req1 and req2.
REQ-020 Round-robin: pointer rr names the preferred of 1/2; after a grant to 1, rr = 2; after a grant to 2, rr = 1; a lone request wins regardless of rr.
REQ-021 Counter starve (8 bit): +1 each cycle in which req1 or req2 is high but neither is granted; cleared on any grant to 1 or 2 or when req1 and req2 are both low; saturates at 255.
REQ-022 FSM states NORMAL and OVERRIDE; NORMAL -> OVERRIDE when starve = STARVE_MAX at a clock edge; OVERRIDE grants the round-robin winner of 1/2 over req0 for one cycle, then returns to NORMAL.
REQ-023 In OVERRIDE, if req1 and req2 are both low, no override grant occurs, req0 is served normally, and the FSM returns to NORMAL.
REQ-024 Back-to-back grants on consecutive cycles shall be supported; the read pipeline holds two reads in flight with no bubble.
REQ-025 rdata shall hold its last value when no rvalidN is high.

Reset
REQ-026 While Reset is high at a clock edge: ackN combinational outputs forced 0, rvalidN = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, rr = 1, starve = 0, FSM = NORMAL.
REQ-027 Reads in flight when Reset asserts shall never produce rvalidN, including in the first cycle after Reset deasserts.

Verification
REQ-028 req2 read addr 0x0040 alone, RAM preloaded 0x0040 = 0xBEEF -> ack2 in cycle t, mem_addr = 0x0040 and mem_we = 0 in t+1, rvalid2 = 1 and rdata = 0xBEEF in t+2 only.
REQ-029 req1 and req2 both write continuously, req0 low, from reset -> grants alternate 1,2,1,2; ack1 first; mem_we = 1 each cycle; no rvalid.
REQ-030 req0 and req1 held high continuously, STARVE_MAX = 8 -> ack0 for 8 cycles, ack1 on the 9th, repeating every 9 cycles.
REQ-031 Reads from 0, 1, 2 granted on three consecutive cycles -> rvalid0, rvalid1, rvalid2 on three consecutive cycles, each with its own address's data.
REQ-032 Reset asserted one cycle after a read grant -> no rvalid ever produced for that read; all outputs at their REQ-026 values.
REQ-033 STARVE_MAX = 1, req0 always high, req1 and req2 alternately pulsed -> starve clears on each low-priority grant; no cycle has two acks.
